// File: rtl/coefficient_keypad_entry.sv
// Keypad entry of a 3x3 system matrix plus right-hand side as Q12.4 coefficients.
// Latency: a key takes effect one cycle after its strobe; a commit takes 5 busy cycles (4 CONVERT + 1 STORE).
// Backpressure: none; keys arriving while busy (or any key but F once done) are dropped.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   key_valid, key_code      one-cycle key strobe and its 4-bit code
//   A00..A22, C0..C2         stored Q12.4 coefficients
//   LU_en                    all 12 coefficients stored
//   entry_idx                index of the coefficient being entered (12 when done)
//   entry_val                live integer-part preview of the current entry
//   busy                     fraction conversion / store in progress
//   entry_ovf                sticky: an integer digit was rejected for overflow
module coefficient_keypad_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] A00,
  output logic [15:0] A01,
  output logic [15:0] A02,
  output logic [15:0] A10,
  output logic [15:0] A11,
  output logic [15:0] A12,
  output logic [15:0] A20,
  output logic [15:0] A21,
  output logic [15:0] A22,
  output logic [15:0] C0,
  output logic [15:0] C1,
  output logic [15:0] C2,
  output logic        LU_en,
  output logic [3:0]  entry_idx,
  output logic [15:0] entry_val,
  output logic        busy,
  output logic        entry_ovf
);

  typedef enum logic [2:0] {
    ST_INT,
    ST_FRAC,
    ST_CONVERT,
    ST_STORE,
    ST_DONE
  } state_t;

  localparam logic [3:0] KEY_DOT     = 4'hA;
  localparam logic [3:0] KEY_SIGN    = 4'hB;
  localparam logic [3:0] KEY_CLEAR   = 4'hC;
  localparam logic [3:0] KEY_ENTER   = 4'hD;
  localparam logic [3:0] KEY_RESTART = 4'hF;

  state_t      state, next_state;
  logic [15:0] coef [12];
  logic [11:0] int_acc;
  logic [13:0] frac_acc;
  logic [2:0]  frac_cnt;
  logic        neg;
  logic [13:0] den;
  logic [13:0] rem;
  logic [3:0]  frac4;
  logic [1:0]  conv_cnt;

  logic        is_digit;
  logic        restart;
  logic [15:0] int_calc;
  logic [13:0] frac_calc;
  logic [13:0] den_sel;
  logic [14:0] rem2;
  logic [15:0] mag;
  logic [15:0] store_val;
  logic [15:0] preview;

  assign is_digit  = (key_code <= 4'd9);
  // int_acc never exceeds 2047, so the 16-bit product cannot wrap
  assign int_calc  = 16'(int_acc) * 16'd10 + 16'(key_code);
  // only used while frac_cnt < 4, i.e. frac_acc <= 999
  assign frac_calc = frac_acc * 14'd10 + 14'(key_code);
  // rem stays below den (<= 10000), so doubling needs one extra bit
  assign rem2      = {rem, 1'b0};
  assign mag       = {int_acc, frac4};
  // -0 folds to 0x0000 naturally in two's complement
  assign store_val = neg ? -mag : mag;
  assign preview   = {int_acc, 4'b0000};
  assign entry_val = neg ? -preview : preview;
  assign busy      = (state == ST_CONVERT) || (state == ST_STORE);

  assign restart = key_valid && (key_code == KEY_RESTART) &&
                   ((state == ST_INT) || (state == ST_FRAC) || (state == ST_DONE));

  always_comb begin
    den_sel = 14'd1;
    case (frac_cnt)
      3'd1:    den_sel = 14'd10;
      3'd2:    den_sel = 14'd100;
      3'd3:    den_sel = 14'd1000;
      3'd4:    den_sel = 14'd10000;
      default: den_sel = 14'd1;
    endcase
  end

  assign A00 = coef[0];
  assign A01 = coef[1];
  assign A02 = coef[2];
  assign A10 = coef[3];
  assign A11 = coef[4];
  assign A12 = coef[5];
  assign A20 = coef[6];
  assign A21 = coef[7];
  assign A22 = coef[8];
  assign C0  = coef[9];
  assign C1  = coef[10];
  assign C2  = coef[11];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_INT: begin
        if (key_valid) begin
          if (key_code == KEY_DOT)        next_state = ST_FRAC;
          else if (key_code == KEY_ENTER) next_state = ST_CONVERT;
        end
      end
      ST_FRAC: begin
        if (key_valid) begin
          if (key_code == KEY_ENTER)                                    next_state = ST_CONVERT;
          else if (key_code == KEY_CLEAR || key_code == KEY_RESTART)    next_state = ST_INT;
        end
      end
      ST_CONVERT: begin
        if (conv_cnt == 2'd3) next_state = ST_STORE;
      end
      ST_STORE: begin
        next_state = (entry_idx == 4'd11) ? ST_DONE : ST_INT;
      end
      ST_DONE: begin
        if (key_valid && key_code == KEY_RESTART) next_state = ST_INT;
      end
      default: next_state = ST_INT;
    endcase
  end

  // Reset and the F key clear exactly the same state.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int i = 0; i < 12; i++) coef[i] <= '0;
      int_acc   <= '0;
      frac_acc  <= '0;
      frac_cnt  <= '0;
      neg       <= 1'b0;
      entry_ovf <= 1'b0;
      entry_idx <= '0;
      LU_en     <= 1'b0;
      den       <= 14'd1;
      rem       <= '0;
      frac4     <= '0;
      conv_cnt  <= '0;
    end else begin
      case (state)
        ST_INT, ST_FRAC: begin
          if (key_valid) begin
            if (is_digit) begin
              if (state == ST_INT) begin
                if (int_calc <= 16'd2047) int_acc   <= int_calc[11:0];
                else                      entry_ovf <= 1'b1;
              end else if (frac_cnt < 3'd4) begin
                frac_acc <= frac_calc;
                frac_cnt <= frac_cnt + 3'd1;
              end
            end else begin
              case (key_code)
                KEY_SIGN: neg <= ~neg;
                KEY_CLEAR: begin
                  int_acc   <= '0;
                  frac_acc  <= '0;
                  frac_cnt  <= '0;
                  neg       <= 1'b0;
                  entry_ovf <= 1'b0;
                end
                KEY_ENTER: begin
                  den      <= den_sel;
                  rem      <= frac_acc;
                  frac4    <= '0;
                  conv_cnt <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        ST_CONVERT: begin
          // one restoring-division step: frac4 = floor(frac_acc*16/den)
          if (rem2 >= {1'b0, den}) begin
            rem   <= 14'(rem2 - {1'b0, den});
            frac4 <= {frac4[2:0], 1'b1};
          end else begin
            rem   <= rem2[13:0];
            frac4 <= {frac4[2:0], 1'b0};
          end
          conv_cnt <= conv_cnt + 2'd1;
        end
        ST_STORE: begin
          coef[entry_idx] <= store_val;
          entry_idx       <= entry_idx + 4'd1;
          int_acc         <= '0;
          frac_acc        <= '0;
          frac_cnt        <= '0;
          neg             <= 1'b0;
          entry_ovf       <= 1'b0;
          if (entry_idx == 4'd11) LU_en <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coefficient_keypad_entry.sv
// Self-checking bench for coefficient_keypad_entry.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_coefficient_keypad_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] A00, A01, A02, A10, A11, A12, A20, A21, A22, C0, C1, C2;
  logic        LU_en;
  logic [3:0]  entry_idx;
  logic [15:0] entry_val;
  logic        busy;
  logic        entry_ovf;

  always #5 clk = ~clk;

  coefficient_keypad_entry dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .A00(A00), .A01(A01), .A02(A02), .A10(A10), .A11(A11), .A12(A12),
    .A20(A20), .A21(A21), .A22(A22), .C0(C0), .C1(C1), .C2(C2),
    .LU_en(LU_en), .entry_idx(entry_idx), .entry_val(entry_val),
    .busy(busy), .entry_ovf(entry_ovf)
  );

  logic [15:0] coefs [12];
  assign coefs[0] = A00;  assign coefs[1]  = A01; assign coefs[2]  = A02;
  assign coefs[3] = A10;  assign coefs[4]  = A11; assign coefs[5]  = A12;
  assign coefs[6] = A20;  assign coefs[7]  = A21; assign coefs[8]  = A22;
  assign coefs[9] = C0;   assign coefs[10] = C1;  assign coefs[11] = C2;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_idx = 0;
  logic [3:0] prev_idx = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard: every increment of entry_idx is one completed store.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && entry_idx == prev_idx + 4'd1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_store", {28'd0, prev_idx}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("store_idx", {28'd0, prev_idx}, {28'd0, e.idx});
        chk("store_val", {16'd0, coefs[prev_idx]}, {16'd0, e.val});
      end
    end
    prev_idx = entry_idx;
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Push the expected store, press D, then measure the busy window.
  task automatic commit(input logic [15:0] want);
    int n;
    int lu_seen;
    exp_t e;
    e.idx = 4'(model_idx);
    e.val = want;
    exp_q.push_back(e);
    model_idx++;
    press(4'hD);
    n = 0;
    lu_seen = 0;
    while (busy === 1'b1 && n < 20) begin
      if (LU_en === 1'b1) lu_seen++;
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 5);
    chk("lu_en_while_busy", lu_seen, 0);
  endtask

  task automatic enter_int(input int v);
    int m;
    int digs [4];
    int nd;
    m  = (v < 0) ? -v : v;
    nd = 0;
    do begin
      digs[nd] = m % 10;
      m = m / 10;
      nd++;
    end while (m != 0 && nd < 4);
    for (int i = nd - 1; i >= 0; i--) press(4'(digs[i]));
    if (v < 0) press(4'hB);
    commit(16'(v * 16));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 12; i++) chk(tag, {16'd0, coefs[i]}, 32'd0);
  endtask

  int vals [12] = '{4, 8, 1, 1, 7, -3, 2, -3, 2, 2, -14, 2};

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_coef");
    chk("reset_lu_en", {31'd0, LU_en}, 0);
    chk("reset_idx", {28'd0, entry_idx}, 0);
    chk("reset_entry_val", {16'd0, entry_val}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_ovf", {31'd0, entry_ovf}, 0);
    rst = 1'b0;

    // "4",D
    press(4'h4);
    chk("preview_4", {16'd0, entry_val}, 32'h0040);
    commit(16'h0040);
    chk("idx_after_first", {28'd0, entry_idx}, 1);
    // "3",B,D and "1",A,"5",D
    press(4'h3); press(4'hB);
    chk("preview_neg3", {16'd0, entry_val}, 32'hFFD0);
    commit(16'hFFD0);
    press(4'h1); press(4'hA); press(4'h5); commit(16'h0018);
    // fifth fraction digit dropped, then 2.99
    press(4'h0); press(4'hA);
    for (int i = 0; i < 4; i++) press(4'h3);
    press(4'h7); commit(16'h0005);
    press(4'h2); press(4'hA); press(4'h9); press(4'h9); commit(16'h002F);

    // integer overflow and clear
    press(4'h2); press(4'h0); press(4'h4); press(4'h8);
    chk("ovf_set", {31'd0, entry_ovf}, 1);
    chk("ovf_preview", {16'd0, entry_val}, 32'h0CC0);
    press(4'hC);
    chk("clear_preview", {16'd0, entry_val}, 0);
    chk("clear_ovf", {31'd0, entry_ovf}, 0);

    // F and a digit during CONVERT are dropped
    begin
      exp_t e;
      int n;
      press(4'h6);
      e.idx = 4'(model_idx); e.val = 16'h0060; exp_q.push_back(e); model_idx++;
      press(4'hD);
      press(4'hF);
      press(4'h9);
      n = 0;
      while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
      chk("conv_keys_busy_end", {31'd0, busy}, 0);
      chk("conv_keys_idx", {28'd0, entry_idx}, 6);
      chk("conv_keys_a12", {16'd0, A12}, 32'h0060);
      chk("conv_keys_a00", {16'd0, A00}, 32'h0040);
    end

    // rst in the first CONVERT cycle
    press(4'h1);
    press(4'hD);
    chk("busy_before_rst", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_idx = 0;
    check_all_zero("rst_conv_coef");
    chk("rst_conv_busy", {31'd0, busy}, 0);
    chk("rst_conv_idx", {28'd0, entry_idx}, 0);

    // full matrix
    for (int i = 0; i < 12; i++) enter_int(vals[i]);
    chk("done_lu_en", {31'd0, LU_en}, 1);
    chk("done_idx", {28'd0, entry_idx}, 12);
    for (int i = 0; i < 12; i++) chk("matrix_reg", {16'd0, coefs[i]}, {16'd0, 16'(vals[i] * 16)});
    press(4'h5); press(4'hD);
    @(negedge clk);
    chk("done_ignore_busy", {31'd0, busy}, 0);
    chk("done_ignore_idx", {28'd0, entry_idx}, 12);
    chk("done_ignore_a00", {16'd0, A00}, 32'h0040);

    // F in DONE
    press(4'hF);
    model_idx = 0;
    check_all_zero("restart_coef");
    chk("restart_lu_en", {31'd0, LU_en}, 0);
    chk("restart_idx", {28'd0, entry_idx}, 0);

    // negative zero and extreme magnitudes
    press(4'hB); press(4'h0); commit(16'h0000);
    press(4'h2); press(4'h0); press(4'h4); press(4'h7); press(4'hA);
    for (int i = 0; i < 4; i++) press(4'h9);
    commit(16'h7FFF);
    press(4'hB);
    press(4'h2); press(4'h0); press(4'h4); press(4'h7); press(4'hA);
    for (int i = 0; i < 4; i++) press(4'h9);
    commit(16'h8001);
    chk("extreme_lu_en", {31'd0, LU_en}, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coefficient_keypad_entry.md
# coefficient_keypad_entry

Loads the 3x3 system matrix and right-hand side (A00..A22, C0..C2) from a keypad digit stream and presents them as Q12.4 signed fixed-point words to `LU_Decomposition`. It replaces the constant coefficient assignments in the solver top level. When all 12 coefficients are committed, it raises `LU_en`. Decimal entry (sign, up to 4 integer digits, up to 4 fraction digits) is converted to Q12.4 by a short sequential fraction converter.

## Interface
Parameters: none.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `key_valid` input 1: one-cycle strobe; `key_code` is valid this cycle.
- `key_code` input 4: key codes:
  - 0-9 are digits.
  - A is the decimal point.
  - B toggles the sign.
  - C clears the current entry.
  - D commits the current entry (enter).
  - E is unused and ignored.
  - F restarts all entry.
- `A00`,`A01`,`A02`,`A10`,`A11`,`A12`,`A20`,`A21`,`A22`,`C0`,`C1`,`C2` output 16 each: stored coefficients, Q12.4 two's complement.
- `LU_en` output 1: high (level) once all 12 coefficients are stored.
- `entry_idx` output 4: index of the coefficient being entered. Order is 0=A00, 1=A01, 2=A02, 3=A10, …, 8=A22, 9=C0, 10=C1, 11=C2. Holds 12 when done.
- `entry_val` output 16: live Q12.4 preview of the current entry for the display mux, computed as sign applied to {int_acc[11:0],4'b0}.
- `busy` output 1: high in CONVERT and STORE; keys are ignored while high.
- `entry_ovf` output 1: sticky per entry; set when a digit was rejected for integer overflow.

## Operation
- States: INT, FRAC, CONVERT, STORE, DONE. Reset state is INT.
- INT state:
  - A digit sets int_acc = int_acc*10 + d only if the result is ≤ 2047. Otherwise the digit is dropped and `entry_ovf` is set.
  - Key A moves to FRAC.
- FRAC state:
  - A digit sets frac_acc = frac_acc*10 + d and increments frac_cnt, only while frac_cnt < 4. A 5th and later fraction digit is silently ignored.
  - Key A is ignored.
- Keys valid in INT and FRAC:
  - B toggles neg.
  - C zeroes int_acc, frac_acc, frac_cnt, neg and `entry_ovf`, and returns to INT.
  - D goes to CONVERT.
- CONVERT runs exactly 4 cycles of restoring division:
  - Set den = 10^frac_cnt (1, 10, 100, 1000 or 10000) and rem = frac_acc (15 bits).
  - Each cycle: rem = 2*rem; if rem ≥ den then shift in bit 1 and rem -= den, else shift in bit 0.
  - Result frac4 = floor(frac_acc*16/den). frac_cnt=0 yields 0.
- STORE, single cycle:
  - mag = {int_acc[11:0], frac4}.
  - Writes neg ? -mag : mag into the register selected by `entry_idx`.
  - Increments `entry_idx`, clears the entry accumulators, neg and `entry_ovf`.
  - Goes to DONE if the new index is 12, else to INT.
- DONE: `LU_en` = 1. All keys except F are ignored.
- F in any state except CONVERT/STORE:
  - Zeroes all 12 coefficient registers and the accumulators.
  - Sets `entry_idx`=0 and `LU_en`=0, and goes to INT.
- F while `busy` is ignored, like every other key.
- Negative zero stores 0x0000.
- Maximum magnitude is 2047.9375 (0x7FFF). Minimum is -2047.9375 (0x8001). 0x8000 is unreachable.

## Timing
- Reset values:
  - All 12 coefficients 0x0000.
  - `LU_en`=0, `entry_idx`=0, `entry_val`=0x0000.
  - `busy`=0, `entry_ovf`=0.
  - State INT.
- A key sampled at edge N takes effect in the registers and outputs after edge N. `entry_val` reflects a digit one cycle after its strobe.
- Commit timing: D strobe in cycle N, then CONVERT in cycles N+1..N+4 and STORE in N+5. The coefficient, `entry_idx` and state update at the end of N+5.
- `busy` is high in cycles N+1..N+5.
- `LU_en` rises in the cycle after the 12th STORE. It stays high until F or `rst`.
- Back-to-back key strobes are allowed in INT/FRAC; each is processed in its own cycle.
- `rst` mid-CONVERT or in DONE returns every output to its reset value on the next edge.

## Test plan
- Commit key sequence "4",D: after 6 cycles A00=0x0040 and `entry_idx`=1; `busy` is high for exactly 5 cycles.
- Commit "3",B,D at idx 1: A01=0xFFD0. Then "1",A,"5",D: A02=0x0018.
- Commit "0",A,"3","3","3","3","7",D: the 7 is ignored and A10=0x0005. Then "2",A,"9","9",D: A11=0x002F.
- "2","0","4","8": `entry_ovf`=1 and `entry_val`=0x0CC0. C clears it to 0x0000 with `entry_ovf`=0.
- Enter the 12 values 4,8,1,1,7,-3,2,-3,2,2,-14,2:
  - All registers match 0x0040, 0x0080, 0x0010, 0x0010, 0x0070, 0xFFD0, 0x0020, 0xFFD0, 0x0020, 0x0020, 0xFF20, 0x0020.
  - `LU_en` rises one cycle after the last STORE.
  - Subsequent digits are ignored.
- Error cases:
  - F in DONE zeroes all registers and sets `LU_en`=0, `entry_idx`=0.
  - F or a digit during CONVERT is ignored.
  - `rst` asserted in the cycle after D leaves A-registers unchanged from reset and `busy`=0.
